// File: rtl/updown_counter_param_pkg.sv
// Shared definitions for the counter library: direction encodings used by
// every up/down counting element.
package updown_counter_param_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/updown_counter_param_next_calc.sv
// Combinational next-state step for the up/down counter: one count step in
// the requested direction, with wrap/saturate handling at 0 and MAX_VAL.
module updown_next_calc
  import updown_counter_param_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MAX_VAL = (1 << WIDTH) - 1
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up_down,
  input  logic             wrap_en,
  output logic [WIDTH-1:0] next_count,
  output logic             carry_nxt,
  output logic             borrow_nxt
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ONE_C = WIDTH'(1);

  // Bounds are compared explicitly because MAX_VAL may sit below the
  // natural binary rollover point.
  always_comb begin
    next_count = count;
    carry_nxt  = 1'b0;
    borrow_nxt = 1'b0;
    if (up_down == DIR_UP) begin
      if (count >= MAX_C) begin
        carry_nxt  = 1'b1;
        next_count = wrap_en ? '0 : MAX_C;
      end else begin
        next_count = count + ONE_C;
      end
    end else begin
      if (count == '0) begin
        borrow_nxt = 1'b1;
        next_count = wrap_en ? MAX_C : '0;
      end else begin
        next_count = count - ONE_C;
      end
    end
  end

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with modulus, parallel load, enable,
// run-time wrap/saturate selection and registered carry/borrow pulses.
module updown_counter_param
  import updown_counter_param_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX_VAL   = (1 << WIDTH) - 1,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_down,
  input  logic             wrap_en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             carry,
  output logic             borrow
);

  localparam int LIMIT = (WIDTH >= 31) ? 32'h7fff_ffff : ((1 << WIDTH) - 1);

  if (WIDTH < 2 || MAX_VAL < 1 || MAX_VAL > LIMIT ||
      RESET_VAL < 0 || RESET_VAL > MAX_VAL) begin : g_bad_params
    $error("updown_counter_param: illegal WIDTH/MAX_VAL/RESET_VAL combination");
  end

  localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RESET_C = WIDTH'(RESET_VAL);

  // Out-of-range load values are pinned to the terminal count so the
  // register can never hold a value above MAX_VAL.
  function automatic logic [WIDTH-1:0] cnt_clamp(input logic [WIDTH-1:0] v);
    return (v > MAX_C) ? MAX_C : v;
  endfunction

  logic [WIDTH-1:0] count_q, count_d, step_count;
  logic             carry_q, carry_d, borrow_q, borrow_d;
  logic             step_carry, step_borrow;

  updown_next_calc #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL)
  ) u_next_calc (
    .count      (count_q),
    .up_down    (up_down),
    .wrap_en    (wrap_en),
    .next_count (step_count),
    .carry_nxt  (step_carry),
    .borrow_nxt (step_borrow)
  );

  always_comb begin
    count_d  = count_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    if (load) begin
      count_d = cnt_clamp(load_val);
    end else if (en) begin
      count_d  = step_count;
      carry_d  = step_carry;
      borrow_d = step_borrow;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= RESET_C;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
    end
  end

  assign count  = count_q;
  assign carry  = carry_q;
  assign borrow = borrow_q;
  assign at_max = (count_q == MAX_C);
  assign at_min = (count_q == '0);

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed bench for updown_counter_param: a 4-bit modulo-10 instance and
// an 8-bit full-range instance with a non-zero reset value.
module tb_updown_counter_param;
  import updown_counter_param_pkg::*;

  logic       clk = 1'b0;
  logic       rst, en, up_down, wrap_en, load;
  logic [3:0] load_val;
  logic [3:0] count;
  logic       at_max, at_min, carry, borrow;

  logic       rst2, en2, up_down2, wrap_en2, load2;
  logic [7:0] load_val2;
  logic [7:0] count2;
  logic       at_max2, at_min2, carry2, borrow2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .RESET_VAL(0)) dut (
    .clk(clk), .rst(rst), .en(en), .up_down(up_down), .wrap_en(wrap_en),
    .load(load), .load_val(load_val), .count(count), .at_max(at_max),
    .at_min(at_min), .carry(carry), .borrow(borrow)
  );

  updown_counter_param #(.WIDTH(8), .MAX_VAL(255), .RESET_VAL(200)) dut_w (
    .clk(clk), .rst(rst2), .en(en2), .up_down(up_down2), .wrap_en(wrap_en2),
    .load(load2), .load_val(load_val2), .count(count2), .at_max(at_max2),
    .at_min(at_min2), .carry(carry2), .borrow(borrow2)
  );

  // Advance one edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_state();
    rst = 1'b1; rst2 = 1'b1;
    en = 1'b0; up_down = DIR_UP; wrap_en = 1'b1; load = 1'b0; load_val = '0;
    en2 = 1'b0; up_down2 = DIR_UP; wrap_en2 = 1'b1; load2 = 1'b0; load_val2 = '0;
    step(); step();
    checks++;
    if (count !== 4'd0 || at_min !== 1'b1 || at_max !== 1'b0 || carry !== 1'b0 || borrow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: count=%0d at_min=%b at_max=%b carry=%b borrow=%b, want 0 1 0 0 0",
               count, at_min, at_max, carry, borrow);
    end
    checks++;
    if (count2 !== 8'd200 || at_min2 !== 1'b0 || at_max2 !== 1'b0 || carry2 !== 1'b0 || borrow2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state_wide: count=%0d at_min=%b at_max=%b carry=%b borrow=%b, want 200 0 0 0 0",
               count2, at_min2, at_max2, carry2, borrow2);
    end
    rst = 1'b0; rst2 = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    en = 1'b1; up_down = DIR_UP; wrap_en = 1'b1;
    repeat (5) step();
    checks++;
    if (count !== 4'd5) begin
      errors++;
      $display("FAIL async_reset_pre: count=%0d want 5", count);
    end
    en = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (count !== 4'd0 || at_min !== 1'b1 || carry !== 1'b0 || borrow !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: count=%0d at_min=%b carry=%b borrow=%b, want 0 1 0 0",
               count, at_min, carry, borrow);
    end
    #1 rst = 1'b0;
    step();
  endtask

  task automatic test_wrap_up();
    logic [3:0] exp_c [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
    logic       exp_cy[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    en = 1'b1; up_down = DIR_UP; wrap_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      checks++;
      if (count !== exp_c[i] || carry !== exp_cy[i] || borrow !== 1'b0 ||
          at_max !== (exp_c[i] == 4'd9) || at_min !== (exp_c[i] == 4'd0)) begin
        errors++;
        $display("FAIL wrap_up[%0d]: count=%0d carry=%b borrow=%b at_max=%b at_min=%b, want count=%0d carry=%b",
                 i, count, carry, borrow, at_max, at_min, exp_c[i], exp_cy[i]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_saturate_up();
    logic exp_cy[3] = '{0, 1, 1};
    load = 1'b1; load_val = 4'd8;
    step();
    load = 1'b0;
    en = 1'b1; up_down = DIR_UP; wrap_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (count !== 4'd9 || at_max !== 1'b1 || carry !== exp_cy[i] || borrow !== 1'b0) begin
        errors++;
        $display("FAIL saturate_up[%0d]: count=%0d at_max=%b carry=%b borrow=%b, want 9 1 %b 0",
                 i, count, at_max, carry, borrow, exp_cy[i]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_load_clamp_wrap_down();
    logic [3:0] exp_c [11] = '{4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd9, 4'd8};
    logic       exp_bw[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    // Carry is still high from the saturated up-steps; the load must clear it.
    load = 1'b1; load_val = 4'd14;
    step();
    load = 1'b0;
    checks++;
    if (count !== 4'd9 || carry !== 1'b0 || borrow !== 1'b0) begin
      errors++;
      $display("FAIL load_clamp: count=%0d carry=%b borrow=%b, want 9 0 0", count, carry, borrow);
    end
    en = 1'b1; up_down = DIR_DOWN; wrap_en = 1'b1;
    for (int i = 0; i < 11; i++) begin
      step();
      checks++;
      if (count !== exp_c[i] || borrow !== exp_bw[i] || carry !== 1'b0) begin
        errors++;
        $display("FAIL wrap_down[%0d]: count=%0d borrow=%b carry=%b, want count=%0d borrow=%b",
                 i, count, borrow, carry, exp_c[i], exp_bw[i]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_saturate_down();
    logic exp_bw[2] = '{1, 1};
    load = 1'b1; load_val = 4'd0;
    step();
    load = 1'b0;
    en = 1'b1; up_down = DIR_DOWN; wrap_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (count !== 4'd0 || at_min !== 1'b1 || borrow !== exp_bw[i] || carry !== 1'b0) begin
        errors++;
        $display("FAIL saturate_down[%0d]: count=%0d at_min=%b borrow=%b carry=%b, want 0 1 1 0",
                 i, count, at_min, borrow, carry);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_load_priority_hold();
    load = 1'b1; load_val = 4'd3;
    step();
    load = 1'b1; load_val = 4'd6; en = 1'b1; up_down = DIR_UP; wrap_en = 1'b1;
    step();
    load = 1'b0;
    checks++;
    if (count !== 4'd6 || carry !== 1'b0 || borrow !== 1'b0) begin
      errors++;
      $display("FAIL load_priority: count=%0d carry=%b borrow=%b, want 6 0 0", count, carry, borrow);
    end
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      up_down = i[0];
      step();
      checks++;
      if (count !== 4'd6 || carry !== 1'b0 || borrow !== 1'b0) begin
        errors++;
        $display("FAIL hold[%0d]: count=%0d carry=%b borrow=%b, want 6 0 0", i, count, carry, borrow);
      end
    end
  endtask

  task automatic test_wide();
    rst2 = 1'b1;
    #1;
    checks++;
    if (count2 !== 8'd200) begin
      errors++;
      $display("FAIL wide_reset: count=%0d want 200", count2);
    end
    step();
    rst2 = 1'b0;
    en2 = 1'b1; up_down2 = DIR_UP; wrap_en2 = 1'b1;
    repeat (55) step();
    checks++;
    if (count2 !== 8'd255 || at_max2 !== 1'b1 || carry2 !== 1'b0) begin
      errors++;
      $display("FAIL wide_up55: count=%0d at_max=%b carry=%b, want 255 1 0", count2, at_max2, carry2);
    end
    step();
    checks++;
    if (count2 !== 8'd0 || carry2 !== 1'b1 || borrow2 !== 1'b0 || at_min2 !== 1'b1) begin
      errors++;
      $display("FAIL wide_wrap_up: count=%0d carry=%b borrow=%b at_min=%b, want 0 1 0 1",
               count2, carry2, borrow2, at_min2);
    end
    up_down2 = DIR_DOWN;
    step();
    checks++;
    if (count2 !== 8'd255 || borrow2 !== 1'b1 || carry2 !== 1'b0) begin
      errors++;
      $display("FAIL wide_wrap_down: count=%0d borrow=%b carry=%b, want 255 1 0", count2, borrow2, carry2);
    end
    en2 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset_state();
    test_async_reset();
    test_wrap_up();
    test_saturate_up();
    test_load_clamp_wrap_down();
    test_saturate_down();
    test_load_priority_hold();
    test_wide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
